// File: rtl/coherence_bus_controller.sv
// Shared snooping-bus responder: round-robin arbitration of CPU miss/invalidate
// messages, snoop broadcast, a fixed write-back window and a memory response.
module coherence_bus_controller #(
  parameter int NUM_CPUS  = 3,
  parameter int WB_WINDOW = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CPUS*10-1:0]   cpu_bus_out,
  input  logic [NUM_CPUS*8-1:0]    cpu_wb,
  output logic [NUM_CPUS*11-1:0]   cpu_bus_in,
  output logic                     busy,
  output logic                     proto_error
);

  localparam int ID_W = (NUM_CPUS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, SNOOP, WB_WAIT, RESPOND} state_t;

  state_t              state, state_nxt;
  logic [NUM_CPUS-1:0] pending;
  logic [NUM_CPUS-1:0] req_seen, in_service, accept;
  logic [2:0]          pend_type [NUM_CPUS];
  logic [2:0]          pend_addr [NUM_CPUS];
  logic [ID_W-1:0]     req_id, rr_ptr, grant_id, idx;
  logic                grant_vld, grant_take;
  logic [2:0]          req_type, req_addr;
  logic [2:0]          wb_cnt;
  logic [3:0]          mem [8];
  logic                wb_hit;
  logic [3:0]          wb_data;
  logic [3:0]          unused_msg_data;

  // One-hot type: readMiss 100, writeMiss 010, invalidate 001, highest bit wins.
  function automatic logic [2:0] msg_type(input logic [2:0] bits);
    if (bits[2])      return 3'b100;
    else if (bits[1]) return 3'b010;
    else              return 3'b001;
  endfunction

  always_comb begin
    req_seen        = '0;
    in_service      = '0;
    accept          = '0;
    unused_msg_data = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req_seen[i]     = |cpu_bus_out[10*i+7 +: 3];
      in_service[i]   = (state != IDLE) && (req_id == ID_W'(i));
      accept[i]       = req_seen[i] && !pending[i] && !in_service[i];
      unused_msg_data = unused_msg_data ^ cpu_bus_out[10*i +: 4];
    end
  end

  // First pending CPU at or after the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_CPUS);
      if (!grant_vld && pending[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    grant_take = (state == IDLE) && grant_vld;
  end

  // Lowest-index honoured write-back wins.
  always_comb begin
    wb_hit  = 1'b0;
    wb_data = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (!wb_hit && state == WB_WAIT && cpu_wb[8*i+7] &&
          cpu_wb[8*i+4 +: 3] == req_addr && req_id != ID_W'(i)) begin
        wb_hit  = 1'b1;
        wb_data = cpu_wb[8*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SNOOP;
      SNOOP:   state_nxt = WB_WAIT;
      WB_WAIT: if (wb_cnt == 3'(WB_WINDOW - 1)) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      proto_error <= 1'b0;
      req_id      <= '0;
      rr_ptr      <= '0;
      wb_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      proto_error <= proto_error | (|(req_seen & ~accept));
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (accept[i])
          pending[i] <= 1'b1;
        else if (grant_take && grant_id == ID_W'(i))
          pending[i] <= 1'b0;
      end
      if (grant_take) req_id <= grant_id;
      if (state == SNOOP)        wb_cnt <= '0;
      else if (state == WB_WAIT) wb_cnt <= wb_cnt + 3'd1;
      if (state == RESPOND)
        rr_ptr <= (req_id == ID_W'(NUM_CPUS - 1)) ? '0 : req_id + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CPUS; i++) begin
      if (accept[i]) begin
        pend_type[i] <= msg_type(cpu_bus_out[10*i+7 +: 3]);
        pend_addr[i] <= cpu_bus_out[10*i+4 +: 3];
      end
    end
    if (grant_take) begin
      req_type <= pend_type[grant_id];
      req_addr <= pend_addr[grant_id];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 8; a++) mem[a] <= {1'b0, 3'(a)};
    end else if (wb_hit) begin
      mem[req_addr] <= wb_data;
    end
  end

  // Outputs are registered from the current state, one cycle behind the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_bus_in <= '0;
      busy       <= 1'b0;
    end else begin
      busy       <= (state != IDLE);
      cpu_bus_in <= '0;
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (state == SNOOP && req_id != ID_W'(i))
          cpu_bus_in[11*i +: 11] <= {1'b0, req_type, req_addr, 4'b0000};
        else if (state == RESPOND && req_id == ID_W'(i))
          cpu_bus_in[11*i +: 11] <= {1'b1, req_type, req_addr,
                                     req_type[2] ? mem[req_addr] : 4'b0000};
      end
    end
  end

endmodule

// File: doc/coherence_bus_controller.md
Name: coherence_bus_controller

Overview:
- Shared-bus responder for the snooping-cache CPU nodes.
- Accepts one-cycle miss/invalidate messages from each CPU's 10-bit bus output and arbitrates among them round-robin.
- Broadcasts each granted message to the other CPUs as a snoop, and accepts write-backs during a fixed window.
- Completes the transaction by returning the 11-bit response (done flag plus data) from an 8-entry x 4-bit main memory.

Parameters:
- NUM_CPUS, 3, number of CPU nodes attached to the bus (2..4).
- WB_WINDOW, 2, cycles after the snoop broadcast during which write-backs are accepted (1..7).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_bus_out  input  NUM_CPUS*10  per-CPU message, slice i = [10i+9:10i]: [9] readMiss, [8] writeMiss, [7] invalidate, [6:4] address, [3:0] data (unused).
- cpu_wb  input  NUM_CPUS*8  per-CPU write-back, slice i = [8i+7:8i]: [7] valid, [6:4] address, [3:0] data.
- cpu_bus_in  output  NUM_CPUS*11  per-CPU response/snoop, slice i: [10] done, [9:7] message type, [6:4] address, [3:0] data.
- busy  output  1  high while a transaction is in service.
- proto_error  output  1  sticky; set on protocol violation, cleared only by reset.

Behaviour:
- Reset (async, immediate) clears:
  - all cpu_bus_in slices, busy, proto_error, pending flags;
  - round-robin pointer to CPU 0;
  - FSM to IDLE.
  - mem[a] = {1'b0, a} for a = 0..7.
- Request capture:
  - Each edge, a slice with any of bits [9:7] set is latched into pending[i] with type and address.
  - Type priority when several bits are set: readMiss > writeMiss > invalidate.
  - A pulse from a CPU already pending or in service is ignored and sets proto_error.
- States: IDLE, SNOOP, WB_WAIT, RESPOND.
- IDLE:
  - If any pending, grant the first pending CPU at or after the RR pointer, clear its pending flag, and go to SNOOP.
  - A request captured at edge N is granted at edge N+1 at the earliest.
- SNOOP (1 cycle):
  - Every non-requester slice carries {0, type, addr, 0000}.
  - Requester slice is all zero.
  - busy = 1 from SNOOP through RESPOND.
- WB_WAIT (WB_WINDOW cycles):
  - Snoop slices return to zero.
  - A write-back is honoured only if all hold: valid, address == granted address, source is not the requester. Then mem[addr] <= wb data.
  - Several honoured write-backs in one cycle: lowest CPU index wins.
  - Write-backs outside WB_WAIT, or with mismatched address, are ignored (no error).
- RESPOND (1 cycle): requester slice = {1, type, addr, data}.
  - readMiss: data = mem[addr], including any write-back made during this transaction (bypass applied).
  - writeMiss / invalidate: data = 0000; memory unchanged except by write-backs.
  - Then the RR pointer moves to requester+1 mod NUM_CPUS and the FSM returns to IDLE. busy drops in that IDLE cycle; a new grant can issue on the same edge.
- Fixed latency from grant to done = 2 + WB_WINDOW cycles.
- Only one transaction is on the bus at a time. Responses to different CPUs never overlap.
- Reset mid-transaction: transaction is lost, no done pulse is issued, and pending requests are discarded.

Test Plan:
- Read miss, no write-back: CPU0 pulses readMiss at addr 5 -> CPU1/CPU2 see snoop {0,100,101,0000} one cycle; 4 cycles after grant CPU0 sees {1,100,101,0101}; busy low the cycle after.
- Read miss with write-back: CPU1 readMiss at addr 3; during WB_WAIT CPU2 drives wb {1,011,1010} -> CPU1 done data 1010; a later read of addr 3 also returns 1010.
- Arbitration: CPU0, CPU1, CPU2 all pulse writeMiss at addresses 1, 2, 3 in the same cycle -> served in order 0, 1, 2, each done with data 0000; next simultaneous round starts from the advanced RR pointer.
- Protocol errors: CPU0 pulses again while pending -> proto_error = 1 and only one done is issued. Self write-back or mismatched-address write-back -> memory unchanged.
- Type priority: a pulse with bits [9:7] = 111 -> snoop and response carry type 100.
- Reset mid-op: assert reset during WB_WAIT -> all outputs 0 immediately, mem[6] = 0110, no done pulse; the next request is served normally.
